fsb_node_trace_replay: RTL and testbench

Synthesizable trace-replay engine for testbenches. It steps through a ROM of trace entries, one entry per address. Each entry either drives a ring-width packet out on a valid/yumi channel, or consumes a packet from a valid/ready channel and compares it against the expected value. Entries can also wait a number of cycles, or signal done. The block sits between a trace ROM and the design being exercised.

---
 rtl/fsb_trace_pkg.sv | 17 +
 rtl/trace_wait_counter.sv | 36 +++
 rtl/fsb_node_trace_replay.sv | 104 ++++++++++
 tb/tb_fsb_node_trace_replay.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsb_trace_pkg.sv
// Shared definitions for trace replay engines: opcode encoding and field widths.
// Pure declarations: no latency, no flow control.
package fsb_trace_pkg;

    localparam int op_width_lp   = 4;
    localparam int wait_width_lp = 32;

    typedef enum logic [op_width_lp-1:0] {
        NOP       = 4'd0,
        SEND      = 4'd1,
        RECV      = 4'd2,
        DONE      = 4'd3,
        WAIT_LOAD = 4'd4,
        WAIT      = 4'd5
    } op_e;

endpackage

// File: rtl/trace_wait_counter.sv
// Loadable down-counter with a zero flag, shared by the replay engines.
// Load/decrement take effect on the next edge; zero_o reflects the registered count.
// No flow control: the owner decides when to load or decrement.
module trace_wait_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fsb_node_trace_replay.sv
// Trace replay engine: executes one ROM entry per cycle (send, receive/compare, wait, done).
// Decode is combinational from the ROM; address and flags update on the next edge.
// SEND holds until yumi_i, RECV holds until v_i; en_i low freezes everything.
module fsb_node_trace_replay
    import fsb_trace_pkg::*;
#(
    parameter int ring_width_p     = 88,
    parameter int rom_addr_width_p = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        yumi_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [ring_width_p+3:0]     rom_data_i,
    output logic                        done_o,
    output logic                        error_o
);

    logic [rom_addr_width_p-1:0] addr_q, addr_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    logic [op_width_lp-1:0]      op;
    logic [ring_width_p-1:0]     payload;
    logic                        active;
    logic                        adv;
    logic                        cnt_load, cnt_dec, cnt_zero;

    assign op      = rom_data_i[ring_width_p +: op_width_lp];
    assign payload = rom_data_i[ring_width_p-1:0];
    assign active  = en_i & ~done_q & reset_i;

    always_comb begin
        adv      = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        done_d   = done_q;
        error_d  = error_q;
        if (active) begin
            case (op)
                NOP:  adv = 1'b1;
                SEND: adv = yumi_i;
                RECV: begin
                    adv = v_i;
                    if (v_i && (data_i != payload)) begin
                        error_d = 1'b1;
                    end
                end
                DONE: done_d = 1'b1;
                WAIT_LOAD: begin
                    cnt_load = 1'b1;
                    adv      = 1'b1;
                end
                WAIT: begin
                    adv     = cnt_zero;
                    cnt_dec = ~cnt_zero;
                end
                // Unknown opcodes flag an error but keep the replay moving.
                default: begin
                    error_d = 1'b1;
                    adv     = 1'b1;
                end
            endcase
        end
        addr_d = adv ? (addr_q + rom_addr_width_p'(1)) : addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            addr_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    trace_wait_counter #(
        .width_p (wait_width_lp)
    ) wait_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (payload[wait_width_lp-1:0]),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign v_o        = active & (op == SEND);
    assign ready_o    = active & (op == RECV);
    assign data_o     = (op == SEND) ? payload : '0;
    assign rom_addr_o = addr_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_fsb_node_trace_replay.sv
// Randomized trace replay bench: a trace-level model fills scoreboard queues
// (sent packets, receive payloads, per-entry enabled-cycle dwell) that monitors drain.
`timescale 1ns/1ps
module tb_fsb_node_trace_replay;

    localparam int RW    = 88;
    localparam int AW    = 64;
    localparam int DW    = RW + 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, en_i, v_i, yumi_i;
    logic          ready_o, v_o, done_o, error_o;
    logic [RW-1:0] data_i, data_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i;

    logic [DW-1:0] rom [DEPTH];
    assign rom_data_i = rom[rom_addr_o[5:0]];

    fsb_node_trace_replay #(
        .ring_width_p     (RW),
        .rom_addr_width_p (AW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .en_i       (en_i),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    bit            active  = 1'b0;
    logic [RW-1:0] send_q[$];
    logic [RW-1:0] recv_q[$];
    int            dwell_q[$];
    bit            err_exp;
    int            done_idx;
    bit            allow_ill;
    int            mism_pct;
    logic [5:0]    mon_prev;
    int            mon_dwell;
    bit            mon_err_seen;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] op_of(input logic [DW-1:0] e);
        return e[DW-1:RW];
    endfunction

    // Entries whose duration is fixed by the trace alone (not by handshakes).
    function automatic bit timed(input logic [DW-1:0] e);
        logic [3:0] o;
        o = op_of(e);
        return (o == 4'd0) || (o >= 4'd4);
    endfunction

    function automatic logic [RW-1:0] rnd_pl();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[RW-1:0];
    endfunction

    task automatic gen_trace();
        int            r, len;
        logic [3:0]    op;
        logic [RW-1:0] pl;
        len = $urandom_range(6, 40);
        for (int i = 0; i < DEPTH; i++) begin
            pl = rnd_pl();
            r  = $urandom_range(0, 99);
            if (i >= len - 1)  op = 4'd3;
            else if (r < 25)   op = 4'd1;
            else if (r < 50)   op = 4'd2;
            else if (r < 62)   op = 4'd0;
            else if (r < 76) begin
                op = 4'd4;
                pl[31:0] = 32'($urandom_range(0, 5));
            end
            else if (r < 90)   op = 4'd5;
            else if (allow_ill) op = 4'($urandom_range(6, 15));
            else               op = 4'd0;
            rom[i] = {op, pl};
        end
        done_idx = len - 1;
    endtask

    task automatic build_expect();
        int cnt;
        cnt = 0;
        err_exp = 1'b0;
        send_q.delete();
        recv_q.delete();
        dwell_q.delete();
        for (int i = 0; i < done_idx; i++) begin
            case (op_of(rom[i]))
                4'd0: dwell_q.push_back(1);
                4'd1: send_q.push_back(rom[i][RW-1:0]);
                4'd2: recv_q.push_back(rom[i][RW-1:0]);
                4'd4: begin
                    dwell_q.push_back(1);
                    cnt = int'(rom[i][31:0]);
                end
                4'd5: begin
                    dwell_q.push_back(cnt + 1);
                    cnt = 0;
                end
                default: begin
                    dwell_q.push_back(1);
                    err_exp = 1'b1;
                end
            endcase
        end
    endtask

    task automatic apply_reset();
        reset_i = 1'b0;
        en_i    = 1'b1;
        v_i     = 1'b1;
        yumi_i  = 1'b0;
        data_i  = rnd_pl();
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("reset_outputs", {rom_addr_o, v_o, ready_o, done_o, error_o}, '0);
        end
        reset_i      = 1'b1;
        en_i         = 1'b0;
        v_i          = 1'b0;
        build_expect();
        mon_prev     = '0;
        mon_dwell    = 0;
        mon_err_seen = 1'b0;
        active       = 1'b1;
    endtask

    task automatic run(input int max_cyc);
        int c;
        c = 0;
        while (c < max_cyc && done_o !== 1'b1) begin
            @(negedge clk);
            #3;
            c++;
        end
    endtask

    // Driver: random enable, backpressure and receive traffic (some corrupted).
    always @(negedge clk) begin : drv
        bit mism;
        int k;
        if (active) begin
            en_i = ($urandom_range(0, 3) != 0);
            #1;
            yumi_i = v_o && ($urandom_range(0, 1) == 1);
            v_i    = ($urandom_range(0, 1) == 1);
            mism   = ($urandom_range(0, 99) < mism_pct);
            data_i = (recv_q.size() != 0) ? recv_q[0] : rnd_pl();
            if (mism) begin
                k = $urandom_range(0, RW - 1);
                data_i[k] = ~data_i[k];
            end
            if (ready_o && v_i) begin
                chk("recv_avail", (recv_q.size() != 0), 1'b1);
                if (recv_q.size() != 0) begin
                    void'(recv_q.pop_front());
                    if (mism) err_exp = 1'b1;
                end
            end
        end
    end

    // Monitor: packet scoreboard, gating, sticky error and per-entry dwell.
    always @(negedge clk) begin : mon
        logic [5:0]    a;
        logic [DW-1:0] e;
        logic [RW-1:0] exp_d;
        if (active) begin
            #2;
            a = rom_addr_o[5:0];
            e = rom[a];
            if (!en_i || done_o) chk("gated_handshake", {v_o, ready_o}, 2'b00);
            exp_d = (op_of(e) == 4'd1) ? e[RW-1:0] : '0;
            chk("data_o", data_o, exp_d);
            if (mon_err_seen) chk("error_sticky", error_o, 1'b1);
            if (error_o === 1'b1) mon_err_seen = 1'b1;
            if (v_o && yumi_i) begin
                chk("send_avail", (send_q.size() != 0), 1'b1);
                if (send_q.size() != 0) chk("send_pkt", data_o, send_q.pop_front());
            end
            if (a != mon_prev) begin
                if (timed(rom[mon_prev])) begin
                    chk("dwell_avail", (dwell_q.size() != 0), 1'b1);
                    if (dwell_q.size() != 0) chk("dwell_cycles", mon_dwell, dwell_q.pop_front());
                end
                mon_dwell = 0;
            end
            if (en_i && !done_o && timed(e)) mon_dwell++;
            mon_prev = a;
        end
    end

    initial begin
        reset_i = 1'b0;
        en_i    = 1'b0;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        @(negedge clk);
        for (int t = 0; t < 16; t++) begin
            allow_ill = (t % 4 >= 2);
            mism_pct  = (t % 2 == 1) ? 20 : 0;
            gen_trace();
            if (t % 4 == 3) begin
                apply_reset();
                run(15);
                active = 1'b0;
            end
            apply_reset();
            run(3000);
            active = 1'b0;
            chk("done_reached", done_o, 1'b1);
            chk("done_addr", rom_addr_o, AW'(done_idx));
            chk("error_final", error_o, err_exp);
            chk("sends_left", send_q.size(), 0);
            chk("recvs_left", recv_q.size(), 0);
            chk("dwells_left", dwell_q.size(), 0);
            en_i   = 1'b1;
            v_i    = 1'b1;
            yumi_i = 1'b0;
            repeat (2) begin
                @(negedge clk);
                #1;
                chk("frozen_after_done", {rom_addr_o, v_o, ready_o, done_o},
                    {AW'(done_idx), 1'b0, 1'b0, 1'b1});
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
